// File: rtl/pcie_rx_descrambler_16.sv
// pcie_rx_descrambler_16: Gen1/Gen2 receive descrambler, 2 symbols per pclk.
// Optional DESCR_DISABLE_DETECT_EN adds TS-driven scramble-disable detect.
module pcie_rx_descrambler_16 #(
   parameter logic [15:0] SEED        = 16'hFFFF,
   parameter int          TS_BODY_LEN = 15
) (
   input  logic        pclk,
   input  logic        reset,
   input  logic [15:0] data_in,
   input  logic [1:0]  datak_in,
   input  logic        data_valid_in,
   output logic [15:0] data_out,
   output logic [1:0]  datak_out,
   output logic        data_valid_out,
   output logic [1:0]  os_body_out,
`ifdef DESCR_DISABLE_DETECT_EN
   output logic        scramble_disabled_out,
`endif
   output logic [15:0] lfsr_out
);

   localparam int CW = $clog2(TS_BODY_LEN + 1);
   localparam logic [CW-1:0] LEN = CW'(TS_BODY_LEN);

   typedef enum logic [1:0] {
      DESCR,
      POST_COM,
      TS_BODY
   } state_t;

   typedef struct packed {
      state_t        st;
      logic [CW-1:0] cnt;
      logic [15:0]   lfsr;
`ifdef DESCR_DISABLE_DETECT_EN
      logic          cap;
      logic          prev;
      logic          dis;
`endif
   } ctx_t;

   ctx_t       ctx_q;
   ctx_t       c1;
   ctx_t       c2;
   logic [7:0] o0;
   logic [7:0] o1;
   logic       b0;
   logic       b1;

   // One symbol through the rules; chained twice for the two lanes of a word.
   function automatic void sym_step(
      input  ctx_t       c,
      input  logic [7:0] d,
      input  logic       k,
      output ctx_t       n,
      output logic [7:0] o,
      output logic       b
   );
      logic        com;
      logic        skp;
      logic        ctl;
      logic        body;
      logic        dis;
      logic [7:0]  m;
      logic [15:0] l;
      n    = c;
      o    = d;
      b    = 1'b0;
      m    = '0;
      l    = c.lfsr;
      body = 1'b0;
      dis  = 1'b0;
      com  = k && (d == 8'hBC);
      skp  = k && (d == 8'h1C);
      ctl  = k && ((d == 8'h3C) || (d == 8'h7C));
      if (com) begin
         n.st   = POST_COM;
         n.cnt  = '0;
         n.lfsr = SEED;
      end else begin
         unique case (c.st)
            POST_COM: begin
               if (skp || ctl) begin
                  n.st = DESCR;
               end else begin
                  body  = 1'b1;
                  n.cnt = CW'(1);
                  n.st  = (LEN == CW'(1)) ? DESCR : TS_BODY;
               end
            end
            TS_BODY: begin
               body  = 1'b1;
               n.cnt = c.cnt + CW'(1);
               if (n.cnt == LEN) n.st = DESCR;
            end
            default: ;
         endcase
`ifdef DESCR_DISABLE_DETECT_EN
         if (body && (n.cnt == CW'(1))) n.cap = 1'b0;
         if (body && (n.cnt == CW'(5))) n.cap = d[3];
         if (body && (n.cnt == LEN)) begin
            if (n.cap && c.prev) n.dis = 1'b1;
            n.prev = n.cap;
         end
         dis = n.dis;
`endif
         if (!skp) begin
            for (int i = 0; i < 8; i++) begin
               m[i] = l[15];
               l = {l[14:0], 1'b0} ^ (l[15] ? 16'h0039 : 16'h0000);
            end
            n.lfsr = l;
            if (!k && !body && !dis) o = d ^ m;
         end
         b = body;
      end
   endfunction

   always_comb begin
      sym_step(ctx_q, data_in[7:0], datak_in[0], c1, o0, b0);
      sym_step(c1, data_in[15:8], datak_in[1], c2, o1, b1);
   end

   always_ff @(posedge pclk or posedge reset) begin
      if (reset) begin
         ctx_q.st       <= DESCR;
         ctx_q.cnt      <= '0;
         ctx_q.lfsr     <= SEED;
`ifdef DESCR_DISABLE_DETECT_EN
         ctx_q.cap      <= 1'b0;
         ctx_q.prev     <= 1'b0;
         ctx_q.dis      <= 1'b0;
`endif
         data_out       <= '0;
         datak_out      <= '0;
         data_valid_out <= 1'b0;
         os_body_out    <= '0;
      end else begin
         data_valid_out <= data_valid_in;
         if (data_valid_in) begin
            ctx_q       <= c2;
            data_out    <= {o1, o0};
            datak_out   <= datak_in;
            os_body_out <= {b1, b0};
         end
      end
   end

   assign lfsr_out = ctx_q.lfsr;
`ifdef DESCR_DISABLE_DETECT_EN
   assign scramble_disabled_out = ctx_q.dis;
`endif

endmodule

// File: tb/tb_pcie_rx_descrambler_16.sv
// tb_pcie_rx_descrambler_16: directed stimulus against a symbol-stream model.
// Build with +define+DESCR_DISABLE_DETECT_EN to cover the disable detector.
module tb_pcie_rx_descrambler_16;

   localparam logic [15:0] SEED = 16'hFFFF;
   localparam int LEN = 15;
`ifdef DESCR_DISABLE_DETECT_EN
   localparam bit DET = 1'b1;
`else
   localparam bit DET = 1'b0;
`endif

   typedef enum int {
      T_NONE, T_DATA, T_LFEQ, T_LFNE, T_BCLR,
      T_BCNT, T_SAVE, T_SAME, T_DIS
   } tag_t;

   logic        pclk = 1'b0;
   logic        reset = 1'b1;
   logic [15:0] data_in = '0;
   logic [1:0]  datak_in = '0;
   logic        data_valid_in = 1'b0;
   logic [15:0] data_out;
   logic [1:0]  datak_out;
   logic        data_valid_out;
   logic [1:0]  os_body_out;
   logic [15:0] lfsr_out;
`ifdef DESCR_DISABLE_DETECT_EN
   logic        sdis;
`endif

   pcie_rx_descrambler_16 #(
      .SEED(SEED),
      .TS_BODY_LEN(LEN)
   ) dut (
      .pclk(pclk),
      .reset(reset),
      .data_in(data_in),
      .datak_in(datak_in),
      .data_valid_in(data_valid_in),
      .data_out(data_out),
      .datak_out(datak_out),
      .data_valid_out(data_valid_out),
      .os_body_out(os_body_out),
`ifdef DESCR_DISABLE_DETECT_EN
      .scramble_disabled_out(sdis),
`endif
      .lfsr_out(lfsr_out)
   );

   always #5 pclk = ~pclk;

   // Scrambler keystream: byte i is the mask for the i-th advance after SEED.
   logic [7:0]  scr [256];
   logic [15:0] lft [256];
   initial begin : tbl
      logic [15:0] l;
      l = SEED;
      for (int i = 0; i < 256; i++) begin
         lft[i] = l;
         for (int j = 0; j < 8; j++) begin
            scr[i][j] = l[15];
            l = {l[14:0], 1'b0} ^ (l[15] ? 16'h0039 : 16'h0000);
         end
      end
   end

   int          idx;
   bit          post;
   int          left;
   bit          cap;
   bit          prevq;
   bit          mdis;
   logic [15:0] exp_data;
   logic [1:0]  exp_k;
   logic        exp_v;
   logic [1:0]  exp_b;
   logic [15:0] exp_lf;
   logic        exp_dis;
   tag_t        tag_in = T_NONE;
   tag_t        tag_q;
   logic [15:0] val_in = '0;
   logic [15:0] val_q;
   logic [7:0]  o0, o1;
   logic        b0, b1;
   bit          rst_chk = 1'b1;
   int          checks = 0;
   int          errors = 0;
   int          bacc = 0;
   logic [15:0] sv_d;
   logic [15:0] sv_lf;

   task automatic m_sym(input logic [7:0] d, input logic k,
                        output logic [7:0] o, output logic b);
      bit com, skp, ctl;
      com = k && (d == 8'hBC);
      skp = k && (d == 8'h1C);
      ctl = k && ((d == 8'h3C) || (d == 8'h7C));
      o = d;
      b = 1'b0;
      if (com) begin
         idx = 0;
         post = 1'b1;
         left = 0;
      end else begin
         if (post) begin
            post = 1'b0;
            if (!(skp || ctl)) begin
               left = LEN;
               cap = 1'b0;
            end
         end
         if (left > 0) begin
            b = 1'b1;
            if (LEN - left + 1 == 5) cap = d[3];
            left--;
            if (left == 0) begin
               if (cap && prevq) mdis = 1'b1;
               prevq = cap;
            end
         end
         if (!skp) begin
            if (!k && !b && !(DET && mdis)) o = d ^ scr[idx];
            if (idx < 255) idx++;
         end
      end
   endtask

   always @(posedge pclk or posedge reset) begin
      if (reset) begin
         idx = 0; post = 0; left = 0;
         cap = 0; prevq = 0; mdis = 0;
         exp_data = '0; exp_k = '0; exp_v = 1'b0;
         exp_b = '0; exp_lf = 16'hFFFF; exp_dis = 1'b0;
         tag_q = T_NONE; val_q = '0;
      end else begin
         tag_q = tag_in;
         val_q = val_in;
         exp_v = data_valid_in;
         if (data_valid_in) begin
            m_sym(data_in[7:0], datak_in[0], o0, b0);
            m_sym(data_in[15:8], datak_in[1], o1, b1);
            exp_data = {o1, o0};
            exp_k = datak_in;
            exp_b = {b1, b0};
            exp_lf = lft[idx];
            exp_dis = mdis;
         end
      end
   end

   task automatic chk(input string n, input logic [31:0] a,
                      input logic [31:0] e);
      checks++;
      if (a !== e) begin
         errors++;
         $display("FAIL %s got=%h want=%h t=%0t", n, a, e, $time);
      end
   endtask

   always @(negedge pclk) begin
      if (rst_chk) begin
         chk("rst_data", 32'(data_out), 32'h0);
         chk("rst_datak", 32'(datak_out), 32'h0);
         chk("rst_valid", 32'(data_valid_out), 32'h0);
         chk("rst_body", 32'(os_body_out), 32'h0);
         chk("rst_lfsr", 32'(lfsr_out), 32'hFFFF);
      end
      chk("data", 32'(data_out), 32'(exp_data));
      chk("datak", 32'(datak_out), 32'(exp_k));
      chk("valid", 32'(data_valid_out), 32'(exp_v));
      chk("body", 32'(os_body_out), 32'(exp_b));
      chk("lfsr", 32'(lfsr_out), 32'(exp_lf));
`ifdef DESCR_DISABLE_DETECT_EN
      chk("sdis", 32'(sdis), 32'(exp_dis));
`endif
      if (data_valid_out) bacc += $countones(os_body_out);
      case (tag_q)
         T_DATA: chk("lit_data", 32'(data_out), 32'(val_q));
         T_LFEQ: chk("lit_lfsr", 32'(lfsr_out), 32'(val_q));
         T_LFNE: begin
            checks++;
            if (lfsr_out === val_q) begin
               errors++;
               $display("FAIL lit_lfsr_moved got=%h want!=%h",
                        lfsr_out, val_q);
            end
         end
         T_BCLR: bacc = 0;
         T_BCNT: begin
            chk("body_count", 32'(bacc), 32'(val_q));
            bacc = 0;
         end
         T_SAVE: begin
            sv_d = data_out;
            sv_lf = lfsr_out;
         end
         T_SAME: begin
            chk("gap_data", 32'(data_out), 32'(sv_d));
            chk("gap_lfsr", 32'(lfsr_out), 32'(sv_lf));
         end
         T_DIS: begin
`ifdef DESCR_DISABLE_DETECT_EN
            chk("lit_sdis", 32'(sdis), 32'(val_q[0]));
`endif
         end
         default: ;
      endcase
   end

   logic [8:0] q [$];

   task automatic word(input logic [7:0] s0, input logic k0,
                       input logic [7:0] s1, input logic k1,
                       input tag_t t, input logic [15:0] v);
      @(negedge pclk);
      #1;
      data_in = {s1, s0};
      datak_in = {k1, k0};
      data_valid_in = 1'b1;
      tag_in = t;
      val_in = v;
   endtask

   task automatic idle(input tag_t t, input logic [15:0] v);
      @(negedge pclk);
      #1;
      data_in = 16'($urandom);
      datak_in = 2'($urandom);
      data_valid_in = 1'b0;
      tag_in = t;
      val_in = v;
   endtask

   task automatic send_q();
      while (q.size() >= 2) begin
         logic [8:0] a, b;
         a = q.pop_front();
         b = q.pop_front();
         word(a[7:0], a[8], b[7:0], b[8], T_NONE, '0);
      end
   endtask

   task automatic ts(input logic [7:0] ctrl);
      q.push_back({1'b1, 8'hBC});
      q.push_back({1'b1, 8'hF7});
      q.push_back({1'b1, 8'hF7});
      q.push_back({1'b0, 8'h10});
      q.push_back({1'b0, 8'h02});
      q.push_back({1'b0, ctrl});
      for (int i = 0; i < 10; i++) q.push_back({1'b0, 8'h4A});
   endtask

   task automatic do_reset();
      @(negedge pclk);
      #1;
      reset = 1'b1;
      data_valid_in = 1'b0;
      tag_in = T_NONE;
      rst_chk = 1'b1;
      @(negedge pclk);
      #1;
      reset = 1'b0;
      rst_chk = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (2) @(negedge pclk);
      #1;
      reset = 1'b0;
      rst_chk = 1'b0;

      word(8'hBC, 1, 8'h1C, 1, T_NONE, '0);
      word(8'h1C, 1, 8'h1C, 1, T_NONE, '0);
      word(8'hFF, 0, 8'h17, 0, T_DATA, 16'h0000);
      word(8'hC0, 0, 8'h14, 0, T_DATA, 16'h0000);
      idle(T_LFNE, 16'hFFFF);

      idle(T_BCLR, '0);
      ts(8'h00);
      q.push_back({1'b0, 8'hFF});
      q.push_back({1'b0, 8'h17});
      send_q();
      idle(T_BCNT, 16'd15);

      idle(T_BCLR, '0);
      q.push_back({1'b1, 8'h1C});
      ts(8'h00);
      for (int i = 0; i < 3; i++) q.push_back({1'b0, 8'h00});
      send_q();
      idle(T_BCNT, 16'd15);

      idle(T_BCLR, '0);
      ts(8'h00);
      while (q.size() > 7) void'(q.pop_back());
      q.push_back({1'b1, 8'hBC});
      send_q();
      word(8'h1C, 1, 8'h1C, 1, T_LFEQ, 16'hFFFF);
      word(8'hFF, 0, 8'h17, 0, T_DATA, 16'h0000);
      idle(T_BCNT, 16'd6);

      word(8'hBC, 1, 8'hF7, 1, T_NONE, '0);
      word(8'hF7, 1, 8'h10, 0, T_NONE, '0);
      idle(T_SAVE, '0);
      idle(T_SAME, '0);
      idle(T_SAME, '0);
      word(8'h02, 0, 8'h00, 0, T_NONE, '0);
      @(posedge pclk);
      #2;
      reset = 1'b1;
      data_valid_in = 1'b0;
      tag_in = T_NONE;
      rst_chk = 1'b1;
      @(negedge pclk);
      #1;
      reset = 1'b0;
      rst_chk = 1'b0;
      word(8'hFF, 0, 8'h17, 0, T_DATA, 16'h0000);
      idle(T_LFNE, 16'hFFFF);

`ifdef DESCR_DISABLE_DETECT_EN
      do_reset();
      ts(8'h08);
      ts(8'h00);
      send_q();
      idle(T_DIS, 16'd0);
      do_reset();
      ts(8'h08);
      ts(8'h08);
      send_q();
      idle(T_DIS, 16'd1);
      word(8'h5A, 0, 8'h5A, 0, T_DATA, 16'h5A5A);
`endif

      idle(T_NONE, '0);
      idle(T_NONE, '0);
      @(negedge pclk);
      #1;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/pcie_rx_descrambler_16.md
Name: pcie_rx_descrambler_16

Overview:
- Receive-side Gen1/Gen2 (8b/10b) descrambler. It is the inverse of the transmit LFSR scrambler and processes 2 symbols per pclk.
- Sits between the per-lane 8b/10b decoder/elastic buffer and the receive ordered-set/LTSSM logic.
- Tracks COM/SKP rules to keep its LFSR aligned with the transmitter, and passes K-codes and TS1/TS2 bodies through unscrambled.

Parameters:
- SEED, 16'hFFFF, LFSR value loaded on reset and on every COM.
- TS_BODY_LEN, 15, number of symbols after COM in a TS1/TS2 that bypass descrambling.

Ports:
- pclk  input  1  clock.
- reset  input  1  asynchronous, active-high reset.
- data_in  input  16  received symbols; [7:0] is symbol 0 (earlier in time), [15:8] is symbol 1.
- datak_in  input  2  K flag per symbol; bit i belongs to symbol i.
- data_valid_in  input  1  both symbols valid this cycle.
- data_out  output  16  descrambled symbols, same ordering as data_in.
- datak_out  output  2  K flags, delayed copy of datak_in.
- data_valid_out  output  1  delayed copy of data_valid_in.
- os_body_out  output  2  per-symbol flag: symbol is a TS1/TS2 body symbol (not descrambled).
- lfsr_out  output  16  LFSR state after the current word (debug).

Behaviour:
- LFSR:
  - Galois LFSR, G(X)=X^16+X^5+X^4+X^3+1.
  - 8 shifts per advanced symbol; descramble bits LSB first.
  - Mask bit = lfsr[15] before each shift.
  - Reset value = SEED.
- Symbol rules, applied to symbol 0 then symbol 1 within one cycle; the state and LFSR outcome of symbol 0 feed symbol 1 combinationally.
  - COM (K, 8'hBC): output unchanged. LFSR loaded with SEED, no advance. FSM goes to POST_COM.
  - SKP (K, 8'h1C): output unchanged. LFSR not advanced.
  - Other K symbol: output unchanged. LFSR advances 8.
  - D symbol in DESCR state: output = data XOR 8 mask bits. LFSR advances 8.
  - D symbol in TS_BODY: output unchanged. LFSR advances 8. os_body_out bit = 1.
- FSM states:
  - DESCR (reset state).
  - POST_COM: the symbol following COM decides the path.
    - SKP (1C), FTS (K 3C) or IDL (K 7C) → DESCR. SKP/FTS/IDL are handled per the symbol rules.
    - Any other symbol (D, or K PAD F7) → TS_BODY. This symbol is itself body symbol 1; count = 1.
  - TS_BODY: count increments per symbol; at count == TS_BODY_LEN the last body symbol is passed and the FSM returns to DESCR.
    - A COM inside TS_BODY aborts the body: LFSR reseeded, FSM to POST_COM.
- data_valid_in = 0: LFSR, FSM and count hold; data_valid_out = 0 next cycle; data_out/datak_out/os_body_out hold their last value.
- Latency: exactly 1 pclk from input word to output word. Full throughput, no backpressure.
- Reset (any time, including mid-ordered-set) immediately sets:
  - data_out = 0, datak_out = 0, data_valid_out = 0, os_body_out = 0.
  - lfsr = SEED, FSM = DESCR, count = 0.

Optional Feature:
- Macro: DESCR_DISABLE_DETECT_EN.
- With the macro:
  - Capture training-control symbol (body symbol 5) bit 3 of each TS1/TS2.
  - When the bit is 1 in two consecutive complete TS ordered sets, set the sticky disable flag.
  - While the flag is set, all D symbols pass unscrambled; the LFSR still tracks the symbol rules.
  - The flag clears only on reset.
  - Adds output port scramble_disabled_out (1 bit, reset 0), asserted on the cycle the second qualifying body completes.
- Without the macro: no port, no detection logic; descrambling is always active outside TS bodies.

Test Plan:
- Seed/SKP alignment:
  - Stimulus: words {K1C,KBC}, {K1C,K1C}, then D words {17,FF}, {14,C0}.
  - Required: data_out D symbols = 00,00,00,00; os_body_out = 0; lfsr_out after the second D word ≠ FFFF.
- TS1 bypass:
  - Stimulus: KBC followed by 15 D symbols (K PAD F7 for link/lane, 4A identifiers), then D FF,17.
  - Required: all 15 body symbols unchanged with os_body_out = 1. Following D symbols descramble using the LFSR advanced 15×8 from SEED.
- Odd alignment:
  - Stimulus: COM placed in symbol 1, TS body starting in the next word's symbol 0.
  - Required: body count spans the word boundary correctly; exactly 15 symbols flagged.
- Abort:
  - Stimulus: COM at body symbol 7, followed by K1C.
  - Required: FSM returns to DESCR via POST_COM; LFSR = FFFF; later D 00-scrambled data FF,17 → 00,00.
- Valid gaps and reset:
  - Stimulus: deassert data_valid_in for 3 cycles mid-stream, then assert reset mid-TS body.
  - Required: during the gap, outputs hold and the LFSR does not move. On reset, all outputs = 0 immediately and lfsr_out = FFFF.
- With DESCR_DISABLE_DETECT_EN:
  - Stimulus: two consecutive TS1s with symbol 5 = 8'h08, then D 5A.
  - Required: scramble_disabled_out = 1 at the end of the second TS; data_out = 5A unchanged.
  - Also: a single such TS followed by one with symbol 5 = 00 leaves the flag at 0.
